// File: rtl/alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_scheduler
// Description : Round-robin scheduler sharing one ALU datapath between N_REQ
//               requesters; sequences register enables and returns tagged
//               responses, guarding the result-feedback path per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_scheduler #(
   parameter int N_REQ     = 4,
   parameter int MAX_CHAIN = 4,
   localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [6*N_REQ-1:0]   req_cmd,
   output logic [N_REQ-1:0]     req_ready,
   output logic [5:0]           alu_cmd,
   output logic                 datain_reg_en,
   output logic                 aluin_reg_en,
   output logic                 aluout_reg_en,
   input  logic                 alu_error,
   output logic                 resp_valid,
   output logic [ID_W-1:0]      resp_id,
   output logic                 resp_error,
   output logic                 resp_stale,
   output logic                 busy
);

   localparam int CNT_W = $clog2(MAX_CHAIN + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATAIN = 3'd1,
      S_ALUIN  = 3'd2,
      S_RESULT = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t             r_state;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_last_owner;
   logic [ID_W-1:0]    r_cur_id;
   logic [CNT_W-1:0]   r_chain_cnt;
   logic               r_result_valid;
   logic               r_stale;
   logic [5:0]         r_alu_cmd;

   logic [5:0]         w_cmd [N_REQ];
   logic [N_REQ-1:0]   w_fb;
   logic               w_rr_found;
   logic [ID_W-1:0]    w_rr_win;
   logic               w_chain;
   logic [ID_W-1:0]    w_win;
   logic               w_grant;
   logic               w_stale;
   logic [ID_W-1:0]    w_next_ptr;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         assign w_cmd[gi]     = req_cmd[6*gi +: 6];
         assign w_fb[gi]      = (w_cmd[gi][5:4] == 2'b11) || (w_cmd[gi][3:2] == 2'b11);
         assign req_ready[gi] = w_grant && (w_win == ID_W'(gi));
      end
   endgenerate

   always_comb begin : arb
      int idx;
      idx        = 0;
      w_rr_found = 1'b0;
      w_rr_win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!w_rr_found && req_valid[ID_W'(idx)]) begin
            w_rr_found = 1'b1;
            w_rr_win   = ID_W'(idx);
         end
      end
      // The last producer may keep feeding on its own result for a bounded run
      w_chain = r_result_valid && req_valid[r_last_owner] && w_fb[r_last_owner]
                && (r_chain_cnt < CNT_W'(MAX_CHAIN));
      w_win      = w_chain ? r_last_owner : w_rr_win;
      w_grant    = (r_state == S_IDLE) && !rst && (w_chain || w_rr_found);
      w_stale    = w_fb[w_win] && !(r_result_valid && (r_last_owner == w_win));
      w_next_ptr = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_rr_ptr       <= '0;
         r_last_owner   <= '0;
         r_cur_id       <= '0;
         r_chain_cnt    <= '0;
         r_result_valid <= 1'b0;
         r_stale        <= 1'b0;
         r_alu_cmd      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_rr_ptr    <= w_next_ptr;
                  r_alu_cmd   <= w_cmd[w_win];
                  r_cur_id    <= w_win;
                  r_chain_cnt <= w_chain ? r_chain_cnt + CNT_W'(1) : '0;
                  r_stale     <= w_stale;
                  // A stale feedback request never touches the ALU registers
                  r_state     <= w_stale ? S_RESP : S_DATAIN;
               end
            end
            S_DATAIN: r_state <= S_ALUIN;
            S_ALUIN:  r_state <= S_RESULT;
            S_RESULT: begin
               r_last_owner   <= r_cur_id;
               r_result_valid <= 1'b1;
               r_state        <= S_RESP;
            end
            S_RESP:   r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_cmd       = r_alu_cmd;
   assign datain_reg_en = (r_state == S_DATAIN);
   assign aluin_reg_en  = (r_state == S_ALUIN);
   assign aluout_reg_en = (r_state == S_RESULT);
   assign resp_valid    = (r_state == S_RESP);
   assign resp_id       = resp_valid ? r_cur_id : '0;
   assign resp_stale    = resp_valid && r_stale;
   assign resp_error    = resp_valid && !r_stale && alu_error;
   assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_scheduler
// Description : Directed self-checking bench for alu_req_scheduler with a
//               response scoreboard (N_REQ=4, MAX_CHAIN=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [23:0] req_cmd;
   logic [3:0]  req_ready;
   logic [5:0]  alu_cmd;
   logic        datain_reg_en, aluin_reg_en, aluout_reg_en;
   logic        alu_error;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic        resp_error, resp_stale, busy;

   typedef struct packed {
      logic [1:0] id;
      logic       err;
      logic       stale;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   alu_req_scheduler #(.N_REQ(4), .MAX_CHAIN(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
      .alu_cmd(alu_cmd),
      .datain_reg_en(datain_reg_en), .aluin_reg_en(aluin_reg_en),
      .aluout_reg_en(aluout_reg_en), .alu_error(alu_error),
      .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_error(resp_error), .resp_stale(resp_stale), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_cmd(input int i, input logic [5:0] c);
      req_cmd[6*i +: 6] = c;
   endtask

   task automatic check_resp();
      exp_t e;
      chk("resp_valid", 32'(resp_valid), 32'd1);
      n_checks++;
      assert (sb.size() > 0) else begin
         n_errors++;
         $error("FAIL sb_underflow: observed %0d entries expected >0", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("resp_id", 32'(resp_id), 32'(e.id));
         chk("resp_error", 32'(resp_error), 32'(e.err));
         chk("resp_stale", 32'(resp_stale), 32'(e.stale));
      end
   endtask

   // Called at the negedge of the IDLE cycle in which the grant is expected;
   // returns one tick after the DUT has come back to IDLE.
   task automatic expect_cmd(input int id, input logic [5:0] cmd, input bit stale,
                             input bit err, input bit drop);
      exp_t e;
      chk("grant", 32'(req_ready), 32'(1) << id);
      chk("busy_idle", 32'(busy), 32'd0);
      e.id = id[1:0]; e.err = stale ? 1'b0 : err; e.stale = stale;
      sb.push_back(e);
      @(posedge clk); #1;
      if (drop) req_valid[id] = 1'b0;
      if (!stale) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("enables", 32'({datain_reg_en, aluin_reg_en, aluout_reg_en}), 32'd4 >> c);
            chk("alu_cmd", 32'(alu_cmd), 32'(cmd));
            chk("no_resp", 32'({resp_valid, req_ready}), 32'd0);
            @(posedge clk); #1;
         end
         alu_error = err;
      end
      @(negedge clk);
      chk("enables_resp", 32'({datain_reg_en, aluin_reg_en, aluout_reg_en}), 32'd0);
      chk("alu_cmd_resp", 32'(alu_cmd), 32'(cmd));
      check_resp();
      @(posedge clk); #1;
      alu_error = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; alu_error = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", 32'({req_ready, datain_reg_en, aluin_reg_en, aluout_reg_en,
          resp_valid, resp_error, resp_stale, busy, resp_id, alu_cmd}), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_cmd = '0; alu_error = 1'b0;

      // 1: single normal command
      do_reset();
      set_cmd(0, 6'b00_01_10); req_valid = 4'b0001;
      @(negedge clk);
      expect_cmd(0, 6'b000110, 1'b0, 1'b0, 1'b1);

      // 2: all requesters, round-robin 0,1,2,3,0 at one command per 5 cycles
      do_reset();
      set_cmd(0, 6'b000110); set_cmd(1, 6'b010001);
      set_cmd(2, 6'b100111); set_cmd(3, 6'b011000);
      req_valid = 4'b1111;
      @(negedge clk); expect_cmd(0, 6'b000110, 1'b0, 1'b0, 1'b0);
      @(negedge clk); expect_cmd(1, 6'b010001, 1'b0, 1'b0, 1'b0);
      @(negedge clk); expect_cmd(2, 6'b100111, 1'b0, 1'b0, 1'b0);
      @(negedge clk); expect_cmd(3, 6'b011000, 1'b0, 1'b0, 1'b0);
      @(negedge clk); expect_cmd(0, 6'b000110, 1'b0, 1'b0, 1'b0);
      req_valid = '0;

      // 3: feedback with no result after reset is stale
      do_reset();
      set_cmd(2, 6'b110000); req_valid = 4'b0100;
      @(negedge clk); expect_cmd(2, 6'b110000, 1'b1, 1'b0, 1'b1);

      // 4: feedback chain bounded by MAX_CHAIN=2, then round-robin
      do_reset();
      set_cmd(1, 6'b000101); req_valid = 4'b0010;
      @(negedge clk); expect_cmd(1, 6'b000101, 1'b0, 1'b0, 1'b0);
      set_cmd(1, 6'b001100); set_cmd(0, 6'b000110); req_valid = 4'b0011;
      @(negedge clk); expect_cmd(1, 6'b001100, 1'b0, 1'b0, 1'b0);
      @(negedge clk); expect_cmd(1, 6'b001100, 1'b0, 1'b0, 1'b0);
      @(negedge clk); expect_cmd(0, 6'b000110, 1'b0, 1'b0, 1'b1);
      @(negedge clk); expect_cmd(1, 6'b001100, 1'b1, 1'b0, 1'b1);

      // 5: ALU error reported, then another requester's feedback is stale
      set_cmd(3, 6'b010010); req_valid = 4'b1000;
      @(negedge clk); expect_cmd(3, 6'b010010, 1'b0, 1'b1, 1'b1);
      set_cmd(0, 6'b110000); req_valid = 4'b0001;
      @(negedge clk); expect_cmd(0, 6'b110000, 1'b1, 1'b0, 1'b1);

      // 6: reset during ALUIN drops the command
      set_cmd(1, 6'b000101); req_valid = 4'b0010;
      @(negedge clk);
      chk("grant_r6", 32'(req_ready), 32'd2);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      chk("datain_r6", 32'({datain_reg_en, aluin_reg_en, aluout_reg_en}), 32'd4);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("aluin_r6", 32'({datain_reg_en, aluin_reg_en, aluout_reg_en}), 32'd2);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("outputs_after_rst", 32'({req_ready, datain_reg_en, aluin_reg_en, aluout_reg_en,
          resp_valid, resp_error, resp_stale, busy, resp_id, alu_cmd}), 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("quiet_after_rst", 32'({datain_reg_en, aluin_reg_en, aluout_reg_en,
             resp_valid, busy}), 32'd0);
      end
      @(posedge clk); #1;
      set_cmd(1, 6'b001111); req_valid = 4'b0010;
      @(negedge clk); expect_cmd(1, 6'b001111, 1'b1, 1'b0, 1'b1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
